// File: rtl/axis_position_differentiator.sv
// Decimating differentiator: emits every N-th position sample with its displacement
// since the previous emitted sample, buffered in a 2-entry output FIFO with overflow counting.
module axis_position_differentiator #(
    parameter int S_AXIS_TDATA_WIDTH = 16,
    parameter int M_AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH         = 2
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [15:0]                   decimation,
    output logic [15:0]                   overflow_count,
    input  logic                          S_AXIS_tvalid,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                          M_AXIS_tready
);

    localparam int         W     = S_AXIS_TDATA_WIDTH;
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    logic [15:0]                   cnt_q, cnt_d;
    logic [W-1:0]                  last_pos_q, last_pos_d;
    logic                          primed_q, primed_d;
    logic [15:0]                   ovf_q, ovf_d;
    logic [M_AXIS_TDATA_WIDTH-1:0] mem_q [2];
    logic                          rd_ptr_q, rd_ptr_d;
    logic                          wr_ptr_q, wr_ptr_d;
    logic [1:0]                    count_q, count_d;

    logic [15:0]                   n_minus1;
    logic                          fire;
    logic                          pop;
    logic                          full;
    logic                          push;
    logic                          drop;
    logic [W-1:0]                  velocity;
    logic [M_AXIS_TDATA_WIDTH-1:0] push_word;

    // Handshakes: the slave side is always ready, so every tvalid is an accept; the
    // master side transfers the FIFO head on any edge where tvalid && tready.
    assign n_minus1  = (decimation == 16'd0) ? 16'd0 : decimation - 16'd1;
    assign fire      = S_AXIS_tvalid && (cnt_q >= n_minus1);
    assign pop       = (count_q != 2'd0) && M_AXIS_tready;
    assign full      = (count_q == DEPTH);
    assign push      = fire && (!full || pop);
    assign drop      = fire && full && !pop;
    // Modulo subtraction gives the shortest signed displacement across the wrap.
    assign velocity  = primed_q ? (S_AXIS_tdata - last_pos_q) : '0;
    assign push_word = {velocity, S_AXIS_tdata};

    always_comb begin
        cnt_d      = cnt_q;
        last_pos_d = last_pos_q;
        primed_d   = primed_q;
        ovf_d      = ovf_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (S_AXIS_tvalid) begin
            cnt_d = fire ? 16'd0 : cnt_q + 16'd1;
        end
        if (fire) begin
            last_pos_d = S_AXIS_tdata;
            primed_d   = 1'b1;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q      <= '0;
            last_pos_q <= '0;
            primed_q   <= 1'b0;
            ovf_q      <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            count_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q      <= cnt_d;
            last_pos_q <= last_pos_d;
            primed_q   <= primed_d;
            ovf_q      <= ovf_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            // When full with a pop, wr_ptr equals rd_ptr: the slot being vacated is reused.
            if (push) begin
                mem_q[wr_ptr_q] <= push_word;
            end
        end
    end

    assign S_AXIS_tready  = 1'b1;
    assign M_AXIS_tvalid  = (count_q != 2'd0);
    assign M_AXIS_tdata   = mem_q[rd_ptr_q];
    assign overflow_count = ovf_q;

endmodule

// File: doc/axis_position_differentiator.md
# axis_position_differentiator

Decimating differentiator directly downstream of the position tracker. Accepts the tracker's free-running 16-bit position stream every cycle, emits every N-th sample together with its signed displacement since the previous emitted sample, and buffers results in a 2-entry output FIFO for a consumer that may stall (DMA writer, ram writer). Overflow is counted, never back-pressured, because the tracker ignores tready.

## Interface

- S_AXIS_TDATA_WIDTH, 16, position sample width (signed, two's complement, wraps)
- M_AXIS_TDATA_WIDTH, 32, output word; must equal 2*S_AXIS_TDATA_WIDTH
- FIFO_DEPTH, 2, output buffer entries (fixed at 2; other values unsupported)

- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- decimation  in  16  emit every N-th accepted sample; 0 treated as 1
- overflow_count  out  16  saturating count of dropped emitted samples
- S_AXIS_tvalid  in  1  position sample valid
- S_AXIS_tdata  in  S_AXIS_TDATA_WIDTH  position
- S_AXIS_tready  out  1  constant 1 (including during reset)
- M_AXIS_tvalid  out  1  FIFO not empty
- M_AXIS_tdata  out  M_AXIS_TDATA_WIDTH  {velocity[31:16], position[15:0]} of FIFO head
- M_AXIS_tready  in  1  consumer accepts head

## Operation

- Accept = S_AXIS_tvalid (tready always 1).
- Sample counter cnt (16 bit): on accept, if cnt >= N-1 (N = max(decimation,1)) then fire and cnt <= 0, else cnt <= cnt+1. No accept -> cnt holds.
- decimation sampled at each accept; lowering it below cnt+1 fires on the next accept.
- On fire: velocity = position - last_pos, 16-bit modulo subtraction (wraps; 0x7FFF -> 0x8001 gives +2). last_pos <= position.
- primed flag: first fire after reset emits velocity 0 and sets primed.
- Fire pushes {velocity, position} into FIFO.
- FIFO: 2 entries, head on M_AXIS_tdata. Pop when M_AXIS_tvalid && M_AXIS_tready.
- Push when full: if pop in same cycle, push succeeds (count stays 2); else sample dropped, FIFO unchanged, overflow_count += 1 saturating at 0xFFFF.
- Push into empty FIFO with simultaneous... (no pop possible while empty) -> count 1.
- M_AXIS_tdata holds stable while tvalid && !tready.

## Timing

- Reset values: M_AXIS_tvalid 0, M_AXIS_tdata 0, overflow_count 0, cnt 0, last_pos 0, primed 0, FIFO empty. S_AXIS_tready 1.
- Latency: sample accepted at edge k with fire -> M_AXIS_tvalid high and data visible after edge k (registered, 1 cycle), assuming FIFO not full.
- Pop and push in same edge on non-empty, non-full FIFO: count unchanged, order preserved.
- Reset asserted mid-operation: all state cleared at that edge; buffered samples discarded; inputs during reset ignored. First accept after reset release counts as sample 1.
- overflow_count updates on the same edge as the drop.
- Throughput: one fire per cycle sustained when N = 1 and consumer keeps tready high.

## Test plan

- N=1, tready=1, positions 0,1,3,6 each cycle -> outputs {0,0},{1,1},{2,3},{3,6}, one cycle after each input, tvalid continuous.
- N=4, positions 0..11 ramp by 1 -> outputs at inputs 4,8,12: {0,3},{4,7},{4,11}; none between.
- Wrap: N=1, positions 0x7FFF then 0x8001 then 0x7FFE -> velocities 0, +2 (0x0002), -3 (0xFFFD).
- Stall: N=1, tready=0, 5 samples 10..14 -> FIFO holds {0,10},{1,11}; overflow_count = 3; raise tready -> exactly those two words delivered, then tvalid 0.
- Full with simultaneous pop: FIFO full, tready=1 for one cycle while a fire occurs -> head popped, new sample stored, overflow_count unchanged.
- Reset mid-stream with 2 words buffered, overflow_count=5 -> next cycle tvalid 0, overflow_count 0; next sample yields velocity 0; decimation=0 behaves as N=1.
